// File: rtl/fork_2_l_alu_if.sv
// fork_2_l_alu_if
//   Bundles the decode-side four-phase handshake, the two downstream
//   branch handshakes (load and ALU), the captured payload and the
//   status/counter outputs of the fork_2_l_alu dispatch stage.
//
//   slave  : the dispatch stage itself.
//   master : the surrounding environment. It plays the decode stage, which
//            drives req_in/opcode/data_in. It also plays both downstream
//            branches, which drive ack_ld/ack_alu.
//
//   Signals:
//     req_in, opcode[6:0], data_in[DATA_W] : request + bundled data from decode
//     ack_out                              : acknowledge back to decode
//     req_ld/ack_ld, req_alu/ack_alu       : per-branch four-phase pairs
//     data_out[DATA_W]                     : captured payload
//     err_illegal, err_proto               : one-cycle status pulses
//     cnt_ld[CNT_W], cnt_alu[CNT_W]        : completed-issue counters
interface fork_2_l_alu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              req_in;
  logic [6:0]        opcode;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              req_ld;
  logic              ack_ld;
  logic              req_alu;
  logic              ack_alu;
  logic [DATA_W-1:0] data_out;
  logic              err_illegal;
  logic              err_proto;
  logic [CNT_W-1:0]  cnt_ld;
  logic [CNT_W-1:0]  cnt_alu;

  modport master (
    output req_in, opcode, data_in, ack_ld, ack_alu,
    input  ack_out, req_ld, req_alu, data_out,
           err_illegal, err_proto, cnt_ld, cnt_alu
  );

  modport slave (
    input  req_in, opcode, data_in, ack_ld, ack_alu,
    output ack_out, req_ld, req_alu, data_out,
           err_illegal, err_proto, cnt_ld, cnt_alu
  );
endinterface

// File: rtl/fork_2_l_alu.sv
// fork_2_l_alu
//   Clocked four-phase dispatch stage. It accepts one decoded instruction
//   bundle from decode and steers it by opcode to either the load branch or
//   the ALU branch. Both handshakes complete with return-to-zero. Illegal
//   opcodes are consumed and flagged but never issued downstream.
//   All outputs are registered.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous, active-low reset
//     bus   : fork_2_l_alu_if.slave (handshakes, payload, status, counters)
module fork_2_l_alu #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fork_2_l_alu_if.slave  bus
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DROP,
    S_UP_ACK
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LD,
    SEL_ALU
  } sel_t;

  state_t            state_q, state_d;
  sel_t              sel_q, sel_d;
  sel_t              dec_sel;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_ld_q, cnt_ld_d;
  logic [CNT_W-1:0]  cnt_alu_q, cnt_alu_d;

  logic              ack_out_q, ack_out_d;
  logic              req_ld_q, req_ld_d;
  logic              req_alu_q, req_alu_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_proto_q, err_proto_d;
  logic              ack_ld_prev_q, ack_ld_prev_d;
  logic              ack_alu_prev_q, ack_alu_prev_d;

  // Acknowledge of the selected branch, and of the other one.
  logic              sel_ack;
  logic              oth_ack;
  logic              oth_ack_prev;

  // Opcode decode of the live input (used only at capture time).
  always_comb begin
    dec_sel = SEL_NONE;
    if (bus.opcode == OPC_LOAD) begin
      dec_sel = SEL_LD;
    end else if (bus.opcode == OPC_OP) begin
      dec_sel = SEL_ALU;
    end
  end

  always_comb begin
    sel_ack      = 1'b0;
    oth_ack      = 1'b0;
    oth_ack_prev = 1'b0;
    case (sel_q)
      SEL_LD: begin
        sel_ack      = bus.ack_ld;
        oth_ack      = bus.ack_alu;
        oth_ack_prev = ack_alu_prev_q;
      end
      SEL_ALU: begin
        sel_ack      = bus.ack_alu;
        oth_ack      = bus.ack_ld;
        oth_ack_prev = ack_ld_prev_q;
      end
      default: begin
        sel_ack      = 1'b0;
        oth_ack      = 1'b0;
        oth_ack_prev = 1'b0;
      end
    endcase
  end

  // State register: every flop of the block, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sel_q          <= SEL_NONE;
      data_q         <= '0;
      cnt_ld_q       <= '0;
      cnt_alu_q      <= '0;
      ack_out_q      <= 1'b0;
      req_ld_q       <= 1'b0;
      req_alu_q      <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_proto_q    <= 1'b0;
      ack_ld_prev_q  <= 1'b0;
      ack_alu_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      data_q         <= data_d;
      cnt_ld_q       <= cnt_ld_d;
      cnt_alu_q      <= cnt_alu_d;
      ack_out_q      <= ack_out_d;
      req_ld_q       <= req_ld_d;
      req_alu_q      <= req_alu_d;
      err_illegal_q  <= err_illegal_d;
      err_proto_q    <= err_proto_d;
      ack_ld_prev_q  <= ack_ld_prev_d;
      ack_alu_prev_q <= ack_alu_prev_d;
    end
  end

  // Next-state logic. It also covers payload capture and counter updates,
  // because both are tied to the same transitions.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    cnt_ld_d  = cnt_ld_q;
    cnt_alu_d = cnt_alu_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_in) begin
          sel_d   = dec_sel;
          data_d  = bus.data_in;
          // Illegal opcodes skip the downstream handshake entirely.
          state_d = (dec_sel == SEL_NONE) ? S_UP_ACK : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sel_ack) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (!sel_ack) begin
          state_d = S_UP_ACK;
          if (sel_q == SEL_LD) begin
            cnt_ld_d = cnt_ld_q + CNT_W'(1);
          end else if (sel_q == SEL_ALU) begin
            cnt_alu_d = cnt_alu_q + CNT_W'(1);
          end
        end
      end
      S_UP_ACK: begin
        if (!bus.req_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic. The outputs are Moore functions of the next state, so
  // they appear registered in the same cycle the state does.
  always_comb begin
    ack_out_d      = (state_d == S_UP_ACK);
    req_ld_d       = (state_d == S_ISSUE) && (sel_d == SEL_LD);
    req_alu_d      = (state_d == S_ISSUE) && (sel_d == SEL_ALU);
    err_illegal_d  = (state_q == S_IDLE) && bus.req_in && (dec_sel == SEL_NONE);
    // A non-selected acknowledge is flagged on its rising edge only, so a
    // level held high produces a single pulse.
    err_proto_d    = ((state_q == S_ISSUE) || (state_q == S_DROP)) &&
                     oth_ack && !oth_ack_prev;
    ack_ld_prev_d  = bus.ack_ld;
    ack_alu_prev_d = bus.ack_alu;
  end

  assign bus.ack_out     = ack_out_q;
  assign bus.req_ld      = req_ld_q;
  assign bus.req_alu     = req_alu_q;
  assign bus.data_out    = data_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_proto   = err_proto_q;
  assign bus.cnt_ld      = cnt_ld_q;
  assign bus.cnt_alu     = cnt_alu_q;

endmodule

// File: tb/tb_fork_2_l_alu.sv
// tb_fork_2_l_alu
//   Self-checking bench for fork_2_l_alu. Table-driven transactions use
//   zero-wait neighbours, and hand-written sequences cover the protocol
//   error, early request drop, asynchronous reset and counter wrap.
//   The counter width is reduced to 8 bits so that the wrap stays short.
module tb_fork_2_l_alu;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk;
  logic rst_n;

  fork_2_l_alu_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fork_2_l_alu #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]       op;
    logic [31:0]      data;
    int               exp_cyc;
    logic             exp_ld;
    logic             exp_alu;
    logic             exp_ill;
    logic [CNT_W-1:0] exp_cld;
    logic [CNT_W-1:0] exp_calu;
  } vec_t;

  vec_t vecs[8];

  // Results recorded by run_txn.
  int   r_cyc;
  int   r_req_cyc;
  int   r_ld_n;
  int   r_alu_n;
  int   r_ill_n;
  int   r_perr_n;
  logic r_dstable;
  logic r_onehot_bad;
  logic r_timeout;

  // One complete transaction with zero-wait neighbours. The task is entered
  // at a falling edge and drives req_in immediately, which lets calls run
  // back to back. After capture, opcode and data_in are scrambled so that
  // the captured copy must be the one in use.
  task automatic run_txn(input logic [6:0] op, input logic [31:0] d);
    bit seen_ack = 1'b0;
    r_cyc = 0; r_req_cyc = 0; r_ld_n = 0; r_alu_n = 0; r_ill_n = 0; r_perr_n = 0;
    r_dstable = 1'b1; r_onehot_bad = 1'b0; r_timeout = 1'b1;
    bus.req_in  = 1'b1;
    bus.opcode  = op;
    bus.data_in = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r_cyc++;
      if (bus.req_ld)  r_ld_n++;
      if (bus.req_alu) r_alu_n++;
      if ((bus.req_ld || bus.req_alu) && r_req_cyc == 0) r_req_cyc = r_cyc;
      if (bus.err_illegal) r_ill_n++;
      if (bus.err_proto)   r_perr_n++;
      if (bus.data_out !== d) r_dstable = 1'b0;
      if (int'(bus.req_ld) + int'(bus.req_alu) + int'(bus.ack_out) > 1) r_onehot_bad = 1'b1;
      if (seen_ack && !bus.ack_out) begin
        r_timeout = 1'b0;
        break;
      end
      if (bus.ack_out) begin
        seen_ack   = 1'b1;
        bus.req_in = 1'b0;
      end
      bus.opcode  = ~op;
      bus.data_in = ~d;
      bus.ack_ld  = bus.req_ld;
      bus.ack_alu = bus.req_alu;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_out"},     32'(bus.ack_out),     32'd0);
    chk({tag, "_req_ld"},      32'(bus.req_ld),      32'd0);
    chk({tag, "_req_alu"},     32'(bus.req_alu),     32'd0);
    chk({tag, "_err_illegal"}, 32'(bus.err_illegal), 32'd0);
    chk({tag, "_err_proto"},   32'(bus.err_proto),   32'd0);
    chk({tag, "_data_out"},    bus.data_out,         32'd0);
    chk({tag, "_cnt_ld"},      32'(bus.cnt_ld),      32'd0);
    chk({tag, "_cnt_alu"},     32'(bus.cnt_alu),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_LD,    32'hDEADBEEF, 4, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    vecs[1] = '{OP_ALU,   32'h00000001, 4, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
    vecs[2] = '{OP_ALU,   32'hFFFFFFFF, 4, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2};
    vecs[3] = '{OP_ALU,   32'h5A5A5A5A, 4, 1'b0, 1'b1, 1'b0, 8'd1, 8'd3};
    vecs[4] = '{OP_BR,    32'hCAFEF00D, 2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[5] = '{7'b0000000, 32'h13579BDF, 2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[6] = '{7'b0010011, 32'h2468ACE0, 2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3};
    vecs[7] = '{OP_LD,    32'h0BADF00D, 4, 1'b1, 1'b0, 1'b0, 8'd2, 8'd3};

    rst_n = 1'b0;
    bus.req_in = 1'b0; bus.opcode = '0; bus.data_in = '0;
    bus.ack_ld = 1'b0; bus.ack_alu = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Table-driven transactions, issued back to back.
    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].data);
      chk($sformatf("v%0d_timeout", i),   32'(r_timeout),    32'd0);
      chk($sformatf("v%0d_cycles", i),    32'(r_cyc),        32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_req_ld_n", i),  32'(r_ld_n),       32'(vecs[i].exp_ld));
      chk($sformatf("v%0d_req_alu_n", i), 32'(r_alu_n),      32'(vecs[i].exp_alu));
      chk($sformatf("v%0d_req_lat", i),   32'(r_req_cyc),    (vecs[i].exp_ld || vecs[i].exp_alu) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_illegal_n", i), 32'(r_ill_n),      32'(vecs[i].exp_ill));
      chk($sformatf("v%0d_proto_n", i),   32'(r_perr_n),     32'd0);
      chk($sformatf("v%0d_data_hold", i), 32'(r_dstable),    32'd1);
      chk($sformatf("v%0d_onehot", i),    32'(r_onehot_bad), 32'd0);
      chk($sformatf("v%0d_cnt_ld", i),    32'(bus.cnt_ld),   32'(vecs[i].exp_cld));
      chk($sformatf("v%0d_cnt_alu", i),   32'(bus.cnt_alu),  32'(vecs[i].exp_calu));
    end

    // ALU transaction in which ack_ld rises during ISSUE and stays high.
    bus.req_in = 1'b1; bus.opcode = OP_ALU; bus.data_in = 32'hA5A50001;
    @(negedge clk);
    chk("perr_req_alu_up", 32'(bus.req_alu), 32'd1);
    bus.ack_ld = 1'b1;
    @(negedge clk);
    chk("perr_pulse",      32'(bus.err_proto), 32'd1);
    chk("perr_stay_issue", 32'(bus.req_alu),   32'd1);
    chk("perr_no_req_ld",  32'(bus.req_ld),    32'd0);
    bus.ack_alu = 1'b1;
    @(negedge clk);
    chk("perr_single",     32'(bus.err_proto), 32'd0);
    chk("perr_req_alu_dn", 32'(bus.req_alu),   32'd0);
    bus.ack_alu = 1'b0; bus.ack_ld = 1'b0;
    @(negedge clk);
    chk("perr_ack_out",    32'(bus.ack_out),   32'd1);
    chk("perr_cnt_alu",    32'(bus.cnt_alu),   32'd4);
    chk("perr_cnt_ld",     32'(bus.cnt_ld),    32'd2);
    bus.req_in = 1'b0;
    @(negedge clk);
    chk("perr_ack_drop",   32'(bus.ack_out),   32'd0);

    // Load transaction with req_in dropped straight after capture, and the
    // payload changed at the same time.
    bus.req_in = 1'b1; bus.opcode = OP_LD; bus.data_in = 32'h12345678;
    @(negedge clk);
    chk("early_req_ld", 32'(bus.req_ld), 32'd1);
    bus.req_in = 1'b0; bus.opcode = OP_ALU; bus.data_in = 32'h0;
    bus.ack_ld = 1'b1;
    @(negedge clk);
    chk("early_drop_state", 32'(bus.req_ld), 32'd0);
    bus.ack_ld = 1'b0;
    @(negedge clk);
    chk("early_ack_out", 32'(bus.ack_out),  32'd1);
    chk("early_data",    bus.data_out,      32'h12345678);
    chk("early_cnt_ld",  32'(bus.cnt_ld),   32'd3);
    @(negedge clk);
    chk("early_exit_1cyc", 32'(bus.ack_out), 32'd0);
    chk("early_no_recapture", 32'(bus.req_alu), 32'd0);

    // Asynchronous reset while in DROP (req_ld low, ack_ld still high).
    bus.req_in = 1'b1; bus.opcode = OP_LD; bus.data_in = 32'hFEEDFACE;
    @(negedge clk);
    bus.ack_ld = 1'b1;
    @(negedge clk);
    chk("rst_in_drop", 32'(bus.req_ld), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.req_in = 1'b0; bus.ack_ld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_idle", 32'(bus.req_ld | bus.req_alu | bus.ack_out), 32'd0);
    run_txn(OP_LD, 32'h00C0FFEE);
    chk("after_rst_timeout", 32'(r_timeout),   32'd0);
    chk("after_rst_cycles",  32'(r_cyc),       32'd4);
    chk("after_rst_cnt_ld",  32'(bus.cnt_ld),  32'd1);
    chk("after_rst_cnt_alu", 32'(bus.cnt_alu), 32'd0);

    // Counter wrap: 2^CNT_W - 1 ALU issues reach all-ones, and one more wraps to 0.
    begin
      int n_to = 0;
      for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
        run_txn(OP_ALU, 32'(i));
        if (r_timeout) n_to++;
      end
      chk("wrap_timeouts", 32'(n_to), 32'd0);
    end
    chk("wrap_all_ones", 32'(bus.cnt_alu), 32'h000000FF);
    run_txn(OP_ALU, 32'h0000FFFF);
    chk("wrap_zero",     32'(bus.cnt_alu), 32'd0);
    chk("wrap_cnt_ld",   32'(bus.cnt_ld),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
